// File: rtl/tx_byte_fifo.sv
// Byte FIFO between the encryptor and the UART transmitter. A circular buffer
// absorbs bursts of encrypted bytes, and a small drain FSM launches one byte
// at a time, waiting for the transmitter to go busy and then idle again.
module tx_byte_fifo #(
  parameter int unsigned DEPTH        = 16, // power of two, >= 2
  parameter int unsigned BUSY_TIMEOUT = 4   // >= 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [7:0]               wr_data,
  input  logic                     tx_busy,
  output logic                     tx_start,
  output logic [7:0]               tx_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TmoLast  = TW'(BUSY_TIMEOUT - 1);
  localparam logic [CW-1:0] CntDepth = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StWaitBusy, StWaitDone} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            overflow_q, overflow_d;
  logic            tx_start_q, tx_start_d;
  logic [7:0]      tx_data_q, tx_data_d;
  // Delayed "not empty": gives a freshly written byte one settle cycle, so it
  // launches two edges after the edge that stored it.
  logic            ready_q, ready_d;
  logic [7:0]      mem_q [DEPTH];

  logic push, pop;

  // Flags come straight from the registered count.
  assign full  = (count_q == CntDepth);
  assign empty = (count_q == '0);

  // Storage and occupancy: a write while full is dropped even if a pop
  // frees a slot on the same edge.
  always_comb begin
    push       = wr_en && !full;
    wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d    = count_q + CW'(push) - CW'(pop);
    overflow_d = overflow_q || (wr_en && full);
    ready_d    = !empty;
  end

  // Drain FSM: launch one byte, wait for busy (bounded), then wait for idle.
  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    pop        = 1'b0;
    tx_start_d = 1'b0;
    tx_data_d  = tx_data_q;
    unique case (state_q)
      StIdle: begin
        if (ready_q && !empty && !tx_busy) begin
          pop        = 1'b1;
          tx_start_d = 1'b1;
          tx_data_d  = mem_q[rd_ptr_q];
          tmo_d      = '0;
          state_d    = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (tx_busy) begin
          state_d = StWaitDone;
        end else if (tmo_q == TmoLast) begin
          // Transmitter never acknowledged; give up on the handshake.
          state_d = StIdle;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      StWaitDone: begin
        if (!tx_busy) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Byte storage needs no reset; occupancy tracking makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  // Control state and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tmo_q      <= '0;
      overflow_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      tmo_q      <= tmo_d;
      overflow_q <= overflow_d;
      tx_start_q <= tx_start_d;
      tx_data_q  <= tx_data_d;
      ready_q    <= ready_d;
    end
  end

  assign tx_start = tx_start_q;
  assign tx_data  = tx_data_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_tx_byte_fifo.sv
// Scoreboard bench for tx_byte_fifo: the stimulus side pushes accepted bytes
// into an expected queue; a monitor pops one per observed launch.
module tb_tx_byte_fifo;

  localparam int DEPTH = 16;
  localparam int BT    = 4;

  logic       clk, rst, wr_en, tx_busy, tx_start, full, empty, overflow;
  logic [7:0] wr_data, tx_data;
  logic [4:0] count;

  logic hold_busy, mdl_busy, mdl_en;
  int   busy_len;

  assign tx_busy = hold_busy | mdl_busy;

  tx_byte_fifo #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BT)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .tx_busy(tx_busy),
    .tx_start(tx_start), .tx_data(tx_data), .full(full), .empty(empty),
    .count(count), .overflow(overflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: the queue holds exactly the bytes the FIFO should contain.
  logic [7:0] exp_q[$];
  bit         exp_ovf;
  int         total, bad;
  int         cyc, wr_cyc, launch_cnt, last_launch, prev_launch, coincide;
  bit         prev_start;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Transmitter model: busy for busy_len cycles starting just after each launch.
  initial begin
    int left;
    left = 0;
    mdl_busy = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (rst) left = 0;
      else if (tx_start && mdl_en) left = busy_len;
      if (left > 0) begin
        mdl_busy = 1'b1;
        left--;
      end else begin
        mdl_busy = 1'b0;
      end
    end
  end

  // Monitor: compares every launch and the status outputs against the model.
  initial begin
    logic [7:0] d;
    cyc = 0; launch_cnt = 0; last_launch = 0; prev_launch = 0; coincide = 0;
    prev_start = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (rst) begin
        prev_start = 1'b0;
      end else begin
        if (tx_start) begin
          check("no_back_to_back_start", prev_start, 0);
          if (wr_cyc == cyc) coincide++;
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_launch actual=%0h required=none (cycle %0d)", tx_data, cyc);
          end else begin
            d = exp_q.pop_front();
            check("launch_data", tx_data, d);
          end
          launch_cnt++;
          prev_launch = last_launch;
          last_launch = cyc;
        end
        check("count", count, exp_q.size());
        check("count_le_depth", (count <= DEPTH), 1);
        check("empty", empty, (exp_q.size() == 0));
        check("full", full, (exp_q.size() == DEPTH));
        check("overflow", overflow, exp_ovf);
        prev_start = tx_start;
      end
    end
  end

  task automatic wr(input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = d;
    @(posedge clk);
    if (exp_q.size() < DEPTH) begin
      exp_q.push_back(d);
      wr_cyc = cyc + 1;
    end else begin
      exp_ovf = 1'b1;
    end
    #1 wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < max_cyc) begin
      @(posedge clk);
      n++;
    end
    check(name, (n < max_cyc), 1);
    repeat (20) @(posedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int l0, n, guard, c0;
    total = 0; bad = 0; exp_ovf = 1'b0; wr_cyc = -10;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00;
    hold_busy = 1'b0; mdl_en = 1'b0; busy_len = 3;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 8'h00);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Single byte and launch latency.
    mdl_en = 1'b1;
    l0 = launch_cnt;
    wr(8'hA5);
    wait_drain(100, "single_drain");
    check("single_latency", last_launch - wr_cyc, 2);
    check("single_launches", launch_cnt - l0, 1);
    check("single_tx_data_hold", tx_data, 8'hA5);

    // Fill with transmitter busy, then one dropped write.
    @(negedge clk);
    hold_busy = 1'b1;
    l0 = launch_cnt;
    for (int i = 0; i < 16; i++) wr(8'(i));
    @(negedge clk);
    check("fill_full", full, 1);
    check("fill_count", count, 16);
    wr(8'hFF);
    @(negedge clk);
    check("fill_overflow", overflow, 1);
    check("fill_count_after_drop", count, 16);
    check("fill_no_launch", launch_cnt - l0, 0);

    // Drain in order with a 10-cycle busy per frame.
    busy_len = 10;
    hold_busy = 1'b0;
    wait_drain(1000, "drain_done");
    check("drain_launches", launch_cnt - l0, 16);
    check("drain_empty", empty, 1);

    // Stream 40 bytes while draining so writes coincide with pops and pointers wrap.
    busy_len = 2;
    l0 = launch_cnt;
    c0 = coincide;
    n = 0;
    guard = 0;
    while (n < 40 && guard < 5000) begin
      guard++;
      if ($urandom_range(1, 0) == 1 && exp_q.size() < DEPTH) begin
        wr(8'($urandom));
        n++;
      end else begin
        @(negedge clk);
      end
    end
    check("stream_written", n, 40);
    wait_drain(1000, "stream_drain");
    check("stream_launches", launch_cnt - l0, 40);
    check("stream_coincident_pop", (coincide > c0), 1);

    // Transmitter never goes busy: every launch times out after BT cycles.
    mdl_en = 1'b0;
    l0 = launch_cnt;
    for (int i = 0; i < 3; i++) wr(8'($urandom));
    wait_drain(200, "timeout_drain");
    check("timeout_launches", launch_cnt - l0, 3);
    check("timeout_spacing", last_launch - prev_launch, BT + 1);

    // Asynchronous reset during WAIT_DONE with five bytes buffered.
    mdl_en = 1'b1;
    busy_len = 40;
    for (int i = 0; i < 6; i++) wr(8'h50 + 8'(i));
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("pre_reset_count", count, 5);
    check("pre_reset_busy", tx_busy, 1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    mdl_en = 1'b0;
    #1;
    check("async_tx_start", tx_start, 0);
    check("async_tx_data", tx_data, 8'h00);
    check("async_count", count, 0);
    check("async_empty", empty, 1);
    check("async_full", full, 0);
    check("async_overflow", overflow, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    l0 = launch_cnt;
    repeat (20) @(posedge clk);
    check("post_reset_no_launch", launch_cnt - l0, 0);
    mdl_en = 1'b1;
    busy_len = 3;
    wr(8'h3C);
    wait_drain(100, "post_reset_drain");
    check("post_reset_launch", launch_cnt - l0, 1);
    check("post_reset_data", tx_data, 8'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tx_byte_fifo.md
TX_BYTE_FIFO -- requirements
Module: tx_byte_fifo

Interface
REQ-001 Parameter DEPTH, default 16, number of byte entries; SHALL be a power of two, minimum 2.
REQ-002 Parameter BUSY_TIMEOUT, default 4, maximum cycles WAIT_BUSY waits for tx_busy to rise.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wr_en  input  1  one-cycle pulse from encryptor (its send_enable) marking wr_data valid.
REQ-006 wr_data  input  8  encrypted byte to buffer.
REQ-007 tx_busy  input  1  transmitter status; high while a frame is on uart_tx.
REQ-008 tx_start  output  1  one-cycle launch pulse to transmitter send_enable.
REQ-009 tx_data  output  8  byte presented to the transmitter; SHALL be valid whenever tx_start is high.
REQ-010 full  output  1  high when count equals DEPTH.
REQ-011 empty  output  1  high when count equals 0.
REQ-012 count  output  log2(DEPTH)+1  number of stored bytes.
REQ-013 overflow  output  1  sticky flag, set when a write is dropped.

Function
REQ-014 Storage SHALL be a circular buffer with write and read pointers of log2(DEPTH) bits that wrap from DEPTH-1 to 0.
REQ-015 A write with wr_en=1 and full=0 SHALL store wr_data at the write pointer, advance the pointer and increment count.
REQ-016 A write with full=1 SHALL be dropped and SHALL set overflow, even if a pop occurs in the same cycle; full is evaluated on registered count.
REQ-017 A write and a pop in the same cycle SHALL leave count unchanged and advance both pointers.
REQ-018 The drain FSM SHALL have states IDLE, WAIT_BUSY and WAIT_DONE.
REQ-019 IDLE: if empty=0 and tx_busy=0, the FSM SHALL pop one byte into tx_data, pulse tx_start for one cycle and enter WAIT_BUSY; otherwise it SHALL remain in IDLE.
REQ-020 WAIT_BUSY: tx_busy=1 SHALL move to WAIT_DONE; after BUSY_TIMEOUT cycles without tx_busy the FSM SHALL return to IDLE.
REQ-021 WAIT_DONE: tx_busy=0 SHALL move to IDLE.
REQ-022 tx_start SHALL be registered, so it is never high on two consecutive cycles and never high outside the IDLE->WAIT_BUSY transition.
REQ-023 tx_data SHALL hold the last launched byte until the next launch.
REQ-024 Latency: with the FIFO empty, FSM in IDLE and tx_busy=0, a byte written at edge N SHALL appear with tx_start=1 in the cycle after edge N+2.
REQ-025 Bytes SHALL be launched in write order, with no loss or duplication except writes dropped under REQ-016.
REQ-026 full and empty SHALL be derived from registered count and SHALL never be high together.

Reset
REQ-027 While rst=1, regardless of clk: pointers=0, count=0, empty=1, full=0, overflow=0, tx_start=0, tx_data=8'h00, FSM=IDLE.
REQ-028 Reset mid-operation SHALL discard all buffered bytes and drop tx_start immediately, with no further launch until a new write.
REQ-029 overflow SHALL clear only on reset.

Verification
REQ-030 Single byte: reset, tx_busy=0, write 8'hA5 -> tx_start pulses once two cycles later with tx_data=8'hA5, and count returns to 0.
REQ-031 Fill with transmitter held busy: tx_busy=1, write 16 bytes 8'h00..8'h0F -> full=1, count=16, no tx_start; a 17th write 8'hFF -> dropped, overflow=1.
REQ-032 Drain order: from the REQ-031 state, model tx_busy as 10 cycles high per launch -> 16 launches with tx_data 8'h00..8'h0F in order, 8'hFF never sent, empty=1 at end.
REQ-033 Wrap and simultaneous events: stream 40 bytes while draining, with wr_en coinciding with pops -> pointers wrap, all 40 bytes launched in order, count never exceeds DEPTH.
REQ-034 Timeout: tx_busy tied 0 and 3 bytes written -> each launch returns to IDLE after 4 cycles in WAIT_BUSY, and all 3 bytes are sent.
REQ-035 Async reset: assert rst between clock edges during WAIT_DONE with count=5 -> outputs reach reset values before the next edge, and no tx_start occurs after release until a new write.
